// File: rtl/cv32e40p_register_file_sb.sv
// Flip-flop register file (integer + optional FP bank) with busy scoreboard,
// optional write-to-read bypass and a sequential clear engine.
module cv32e40p_register_file_sb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic                  busy_a_o,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic                  busy_b_o,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic [DATA_WIDTH-1:0] rdata_c_o,
    output logic                  busy_c_o,

    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic                  we_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    input  logic                  we_b_i,

    input  logic                  sb_set_i,
    input  logic [ADDR_WIDTH-1:0] sb_addr_i,

    input  logic                  clear_req_i,
    output logic                  clear_busy_o,
    output logic                  clear_done_o
);

    localparam int NUM_WORDS = 2 ** (ADDR_WIDTH - 1);
    localparam int NUM_TOT   = (FPU == 1 && ZFINX == 0) ? 2 * NUM_WORDS : NUM_WORDS;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TOT - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    clear_done_q;

    // Index 0 (x0) has no storage; with no FP bank, MSB-set addresses never match an index.
    logic [DATA_WIDTH-1:0]   mem_q [1:NUM_TOT-1];
    logic [NUM_TOT-1:1]      busy_q;

    logic                    idle;
    logic                    wr_a;
    logic                    wr_b;
    logic                    sb_set;

    logic [ADDR_WIDTH-1:0]   raddr [3];
    logic [DATA_WIDTH-1:0]   rdata [3];
    logic                    busy_rd [3];

    assign idle   = (state_q == S_IDLE);
    assign wr_a   = we_a_i & idle;
    assign wr_b   = we_b_i & idle;
    assign sb_set = sb_set_i & idle;

    assign raddr[0] = raddr_a_i;
    assign raddr[1] = raddr_b_i;
    assign raddr[2] = raddr_c_i;

    assign rdata_a_o = rdata[0];
    assign rdata_b_o = rdata[1];
    assign rdata_c_o = rdata[2];
    assign busy_a_o  = busy_rd[0];
    assign busy_b_o  = busy_rd[1];
    assign busy_c_o  = busy_rd[2];

    assign clear_busy_o = (state_q == S_CLEAR);
    assign clear_done_o = clear_done_q;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p]   = '0;
            busy_rd[p] = 1'b0;
            for (int i = 1; i < NUM_TOT; i++) begin
                if (raddr[p] == ADDR_WIDTH'(i)) begin
                    rdata[p]   = mem_q[i];
                    busy_rd[p] = busy_q[i] & idle;
                    if (BYPASS != 0) begin
                        if (wr_a && waddr_a_i == ADDR_WIDTH'(i)) begin
                            rdata[p] = wdata_a_i;
                        end
                        // Port B completes the long-latency op, so it also retires busy unless re-set now.
                        if (wr_b && waddr_b_i == ADDR_WIDTH'(i)) begin
                            rdata[p] = wdata_b_i;
                            if (!(sb_set && sb_addr_i == ADDR_WIDTH'(i))) begin
                                busy_rd[p] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_req_i) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= ADDR_WIDTH'(1);
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q      <= S_IDLE;
                        clear_done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_TOT; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (state_q == S_CLEAR) begin
            for (int i = 1; i < NUM_TOT; i++) begin
                if (cnt_q == ADDR_WIDTH'(i)) begin
                    mem_q[i] <= '0;
                end
            end
        end else begin
            for (int i = 1; i < NUM_TOT; i++) begin
                if (wr_a && waddr_a_i == ADDR_WIDTH'(i)) begin
                    mem_q[i] <= wdata_a_i;
                end
                if (wr_b && waddr_b_i == ADDR_WIDTH'(i)) begin
                    mem_q[i] <= wdata_b_i;
                end
                if (clear_req_i) begin
                    busy_q[i] <= 1'b0;
                end else begin
                    if (wr_b && waddr_b_i == ADDR_WIDTH'(i)) begin
                        busy_q[i] <= 1'b0;
                    end
                    if (sb_set && sb_addr_i == ADDR_WIDTH'(i)) begin
                        busy_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_register_file_sb.sv
// Bench: FP-bank/bypass instance and integer-only/no-bypass instance on shared stimulus.
module tb_cv32e40p_register_file_sb;

    localparam int AW = 6;
    localparam int DW = 32;

    localparam int FP_RA = 0, FP_RB = 1, FP_RC = 2, FP_BA = 3, FP_BB = 4;
    localparam int FP_CB = 6, FP_CD = 7;
    localparam int NF_RA = 8, NF_RB = 9, NF_BA = 10, NF_CB = 11, NF_CD = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] raddr_a, raddr_b, raddr_c, waddr_a, waddr_b, sb_addr;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          we_a, we_b, sb_set, clear_req;

    logic [DW-1:0] fp_rdata_a, fp_rdata_b, fp_rdata_c;
    logic          fp_busy_a, fp_busy_b, fp_busy_c, fp_clr_busy, fp_clr_done;
    logic [DW-1:0] nf_rdata_a, nf_rdata_b, nf_rdata_c;
    logic          nf_busy_a, nf_busy_b, nf_busy_c, nf_clr_busy, nf_clr_done;

    always #5 clk = ~clk;

    cv32e40p_register_file_sb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1), .ZFINX(0), .BYPASS(1)
    ) u_fp (
        .clk(clk), .rst(rst),
        .raddr_a_i(raddr_a), .rdata_a_o(fp_rdata_a), .busy_a_o(fp_busy_a),
        .raddr_b_i(raddr_b), .rdata_b_o(fp_rdata_b), .busy_b_o(fp_busy_b),
        .raddr_c_i(raddr_c), .rdata_c_o(fp_rdata_c), .busy_c_o(fp_busy_c),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .clear_req_i(clear_req), .clear_busy_o(fp_clr_busy), .clear_done_o(fp_clr_done)
    );

    cv32e40p_register_file_sb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(0), .ZFINX(0), .BYPASS(0)
    ) u_nf (
        .clk(clk), .rst(rst),
        .raddr_a_i(raddr_a), .rdata_a_o(nf_rdata_a), .busy_a_o(nf_busy_a),
        .raddr_b_i(raddr_b), .rdata_b_o(nf_rdata_b), .busy_b_o(nf_busy_b),
        .raddr_c_i(raddr_c), .rdata_c_o(nf_rdata_c), .busy_c_o(nf_busy_c),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .clear_req_i(clear_req), .clear_busy_o(nf_clr_busy), .clear_done_o(nf_clr_done)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            FP_RA:   return fp_rdata_a;
            FP_RB:   return fp_rdata_b;
            FP_RC:   return fp_rdata_c;
            FP_BA:   return 32'(fp_busy_a);
            FP_BB:   return 32'(fp_busy_b);
            FP_CB:   return 32'(fp_clr_busy);
            FP_CD:   return 32'(fp_clr_done);
            NF_RA:   return nf_rdata_a;
            NF_RB:   return nf_rdata_b;
            NF_BA:   return 32'(nf_busy_a);
            NF_CB:   return 32'(nf_clr_busy);
            NF_CD:   return 32'(nf_clr_done);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle mid-cycle, then retire every queued expectation.
    task automatic drain();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we_a = 1'b0; we_b = 1'b0; sb_set = 1'b0; clear_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_fp, cnt_nf, done_fp, done_nf;
        idle_in();
        raddr_a = '0; raddr_b = '0; raddr_c = '0;
        waddr_a = '0; waddr_b = '0; sb_addr = '0;
        wdata_a = '0; wdata_b = '0;

        rst = 1'b1;
        tick(); tick();
        raddr_a = 6'd5;
        expect_val("rst_rdata", FP_RA, 0);
        expect_val("rst_busy", FP_BA, 0);
        expect_val("rst_clr_busy", FP_CB, 0);
        expect_val("rst_clr_done", FP_CD, 0);
        expect_val("rst_nf_clr_busy", NF_CB, 0);
        drain();
        rst = 1'b0;
        tick();

        // x5 write, same-cycle and next-cycle reads
        we_a = 1'b1; waddr_a = 6'd5; wdata_a = 32'h1234; raddr_a = 6'd5;
        expect_val("x5_bypass", FP_RA, 32'h1234);
        expect_val("x5_nobypass", NF_RA, 0);
        drain(); tick(); idle_in();
        expect_val("x5_fp", FP_RA, 32'h1234);
        expect_val("x5_nf", NF_RA, 32'h1234);
        drain(); tick();

        // dual write to x7: port B wins
        we_a = 1'b1; waddr_a = 6'd7; wdata_a = 32'hAAAA;
        we_b = 1'b1; waddr_b = 6'd7; wdata_b = 32'h5555; raddr_b = 6'd7;
        expect_val("x7_bypass_prio", FP_RB, 32'h5555);
        drain(); tick(); idle_in();
        expect_val("x7_fp", FP_RB, 32'h5555);
        expect_val("x7_nf", NF_RB, 32'h5555);
        drain(); tick();

        // x0 is hardwired
        we_a = 1'b1; waddr_a = 6'd0; wdata_a = 32'hFFFF; raddr_c = 6'd0;
        expect_val("x0_nobypass", FP_RC, 0);
        drain(); tick(); idle_in();
        expect_val("x0_read", FP_RC, 0);
        drain(); tick();

        // scoreboard on x9
        sb_set = 1'b1; sb_addr = 6'd9; raddr_a = 6'd9;
        tick(); idle_in();
        expect_val("sb_set_fp", FP_BA, 1);
        expect_val("sb_set_nf", NF_BA, 1);
        drain(); tick();
        we_a = 1'b1; waddr_a = 6'd9; wdata_a = 32'h11;
        tick(); idle_in();
        expect_val("busy_after_a_fp", FP_BA, 1);
        expect_val("busy_after_a_nf", NF_BA, 1);
        drain(); tick();
        we_b = 1'b1; waddr_b = 6'd9; wdata_b = 32'h42;
        expect_val("busy_bclr_bypass", FP_BA, 0);
        expect_val("busy_bclr_nobypass", NF_BA, 1);
        expect_val("x9_bypass", FP_RA, 32'h42);
        drain(); tick(); idle_in();
        expect_val("busy_cleared_fp", FP_BA, 0);
        expect_val("busy_cleared_nf", NF_BA, 0);
        expect_val("x9_fp", FP_RA, 32'h42);
        expect_val("x9_nf", NF_RA, 32'h42);
        drain(); tick();
        sb_set = 1'b1; sb_addr = 6'd9; we_b = 1'b1; waddr_b = 6'd9; wdata_b = 32'h77;
        expect_val("setb_same_cycle_idle", FP_BA, 0);
        drain(); tick(); idle_in();
        expect_val("setb_wins_fp", FP_BA, 1);
        expect_val("setb_wins_nf", NF_BA, 1);
        expect_val("x9_77", FP_RA, 32'h77);
        drain(); tick();
        sb_set = 1'b1; sb_addr = 6'd9; we_b = 1'b1; waddr_b = 6'd9; wdata_b = 32'h78;
        expect_val("setb_same_cycle_busy", FP_BA, 1);
        drain(); tick(); idle_in();
        expect_val("setb_stays_busy", FP_BA, 1);
        drain(); tick();

        // FP bank at addr 35
        we_b = 1'b1; waddr_b = 6'd35; wdata_b = 32'hC0DE;
        tick(); idle_in();
        raddr_a = 6'd35; raddr_b = 6'd3;
        expect_val("f3_fp", FP_RA, 32'hC0DE);
        expect_val("x3_untouched_fp", FP_RB, 0);
        expect_val("f3_absent_nf", NF_RA, 0);
        expect_val("x3_no_alias_nf", NF_RB, 0);
        drain(); tick();
        sb_set = 1'b1; sb_addr = 6'd35;
        tick(); idle_in();
        expect_val("f3_busy_fp", FP_BA, 1);
        expect_val("f3_busy_nf", NF_BA, 0);
        drain(); tick();

        // fill every register, mark x4 and f8 busy
        for (int i = 1; i < 64; i++) begin
            we_a = 1'b1; waddr_a = AW'(i); wdata_a = 32'h1000 + 32'(i);
            sb_set = (i == 4 || i == 40); sb_addr = AW'(i);
            tick();
        end
        idle_in();
        raddr_a = 6'd40; raddr_b = 6'd20;
        expect_val("fill_f8", FP_RA, 32'h1028);
        expect_val("fill_f8_busy", FP_BA, 1);
        expect_val("fill_x20_fp", FP_RB, 32'h1014);
        expect_val("fill_x20_nf", NF_RB, 32'h1014);
        drain(); tick();

        // clear request alongside a write: the write lands first
        clear_req = 1'b1; we_a = 1'b1; waddr_a = 6'd2; wdata_a = 32'hBEEF;
        tick();
        cnt_fp = 0; cnt_nf = 0; done_fp = 0; done_nf = 0;
        for (int c = 0; c < 70; c++) begin
            if (c < 20) begin
                we_a = 1'b1; waddr_a = 6'd2; wdata_a = 32'h1111;
                we_b = 1'b1; waddr_b = 6'd50; wdata_b = 32'h2222;
                sb_set = 1'b1; sb_addr = 6'd3; clear_req = 1'b1;
            end else begin
                idle_in();
            end
            raddr_a = 6'd2; raddr_b = 6'd40;
            if (c == 0) begin
                expect_val("clr_partial_fp", FP_RA, 32'hBEEF);
                expect_val("clr_partial_nf", NF_RA, 32'hBEEF);
                expect_val("clr_busy_masked", FP_BB, 0);
            end
            drain();
            if (fp_clr_busy) cnt_fp++;
            if (nf_clr_busy) cnt_nf++;
            if (fp_clr_done) done_fp++;
            if (nf_clr_done) done_nf++;
            tick();
        end
        idle_in();
        check_eq("clr_cycles_fp", 32'(cnt_fp), 63);
        check_eq("clr_cycles_nf", 32'(cnt_nf), 31);
        check_eq("clr_done_pulses_fp", 32'(done_fp), 1);
        check_eq("clr_done_pulses_nf", 32'(done_nf), 1);
        for (int i = 0; i < 64; i++) begin
            raddr_a = AW'(i);
            expect_val($sformatf("post_clr_rd_%0d", i), FP_RA, 0);
            expect_val($sformatf("post_clr_busy_%0d", i), FP_BA, 0);
            expect_val($sformatf("post_clr_nf_%0d", i), NF_RA, 0);
            drain();
        end
        tick();

        // reset in the middle of a clear, at counter 10
        we_a = 1'b1; waddr_a = 6'd12; wdata_a = 32'h5;
        we_b = 1'b1; waddr_b = 6'd50; wdata_b = 32'h6;
        tick(); idle_in();
        clear_req = 1'b1;
        tick(); idle_in();
        repeat (9) tick();
        raddr_a = 6'd12; raddr_b = 6'd50;
        expect_val("midclr_x12_pending", FP_RA, 32'h5);
        expect_val("midclr_f18_pending", FP_RB, 32'h6);
        expect_val("midclr_busy", FP_CB, 1);
        drain();
        rst = 1'b1;
        #1;
        expect_val("rst_midclr_busy_fp", FP_CB, 0);
        expect_val("rst_midclr_busy_nf", NF_CB, 0);
        expect_val("rst_midclr_done", FP_CD, 0);
        expect_val("rst_midclr_x12", FP_RA, 0);
        expect_val("rst_midclr_f18", FP_RB, 0);
        expect_val("rst_midclr_x12_nf", NF_RA, 0);
        drain();
        tick();
        rst = 1'b0;
        done_fp = 0; done_nf = 0;
        for (int c = 0; c < 6; c++) begin
            drain();
            if (fp_clr_done || fp_clr_busy) done_fp++;
            if (nf_clr_done || nf_clr_busy) done_nf++;
            tick();
        end
        check_eq("no_done_after_rst_fp", 32'(done_fp), 0);
        check_eq("no_done_after_rst_nf", 32'(done_nf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_register_file_sb.md
Name: cv32e40p_register_file_sb

Overview:
Parametrised flip-flop register file that generalises the integer/FP register file. It adds a per-register busy scoreboard for outstanding long-latency writes, optional same-cycle write-to-read bypass, and a sequential clear engine that zeroes the whole file for a secure context switch. It sits in the ID stage: reads feed operand muxes, and busy flags feed hazard/stall logic.

Parameters:
ADDR_WIDTH, 6, address width; MSB selects the FP bank; NUM_WORDS = 2**(ADDR_WIDTH-1) per bank.
DATA_WIDTH, 32, register width.
FPU, 0, 1 = FP bank present.
ZFINX, 0, 1 = FP operations use the integer bank, so the FP bank is absent.
BYPASS, 1, 1 = same-cycle write data forwarded to read ports.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
raddr_a_i/raddr_b_i/raddr_c_i  in  ADDR_WIDTH  read addresses.
rdata_a_o/rdata_b_o/rdata_c_o  out  DATA_WIDTH  read data.
busy_a_o/busy_b_o/busy_c_o  out  1  scoreboard busy for the corresponding read address.
waddr_a_i  in  ADDR_WIDTH  write port A address (ALU writeback).
wdata_a_i  in  DATA_WIDTH  write port A data.
we_a_i  in  1  write port A enable.
waddr_b_i  in  ADDR_WIDTH  write port B address (LSU/multicycle writeback).
wdata_b_i  in  DATA_WIDTH  write port B data.
we_b_i  in  1  write port B enable.
sb_set_i  in  1  mark sb_addr_i busy (long-latency op issued).
sb_addr_i  in  ADDR_WIDTH  scoreboard set address.
clear_req_i  in  1  start the clear sequence.
clear_busy_o  out  1  clear engine active.
clear_done_o  out  1  one-cycle pulse when the clear sequence completes.

Behaviour:
- FP bank exists only when FPU=1 and ZFINX=0, giving NUM_TOT = 2*NUM_WORDS; otherwise NUM_TOT = NUM_WORDS.
- Without an FP bank: MSB-set addresses read 0, report busy 0, and ignore writes and sb_set.
- Register 0: reads 0, writes ignored, sb_set ignored, never bypassed, never busy. FP register 0 is an ordinary register.
- Writes take effect at the clk edge. When both ports hit the same address, port B wins.
- Reads are combinational.
- BYPASS=1: a read address matching an active write in the same cycle returns that write's data (B over A). BYPASS=0: old contents are returned until the next cycle.
- Scoreboard: one busy bit per register.
  - sb_set_i sets busy[sb_addr_i] at the next edge.
  - A port B write clears busy[waddr_b_i]. Port A writes never clear busy.
  - A set and a B-clear to the same address in the same cycle: set wins.
  - busy_x_o = busy[raddr_x]. With BYPASS=1, it reads 0 if a port B write to that address occurs this cycle and no set targets it.
- Clear FSM has states IDLE and CLEAR, with a counter of width ADDR_WIDTH.
  - IDLE -> CLEAR on clear_req_i. On entry the counter loads 1 and all busy bits clear at that edge.
  - In CLEAR: each cycle, reg[counter] <= 0 and counter increments. clear_busy_o = 1.
  - Write ports, sb_set_i and clear_req_i are ignored in CLEAR; upstream stalls on clear_busy_o.
  - Reads return current, partially cleared contents, with no bypass and busy 0.
  - After writing index NUM_TOT-1: -> IDLE, and clear_done_o pulses for 1 cycle in the first IDLE cycle.
  - Total time in CLEAR is NUM_TOT-1 cycles.
  - clear_req_i in the same cycle as a write in IDLE: that write commits, then the clear starts.
- Reset, asynchronous at any time including mid-clear: all registers 0, busy 0, FSM IDLE, counter 0, clear_busy_o 0, clear_done_o 0. Read outputs then reflect zero contents.

Test Plan:
- Reset, then write A x5=0x1234 and read a=5 next cycle -> 0x1234. Same-cycle read with BYPASS=1 -> 0x1234; with BYPASS=0 -> 0.
- A and B both write x7 (0xAAAA, 0x5555) -> x7=0x5555 next cycle. Write x0=0xFFFF -> reads 0.
- sb_set x9 -> busy_a_o=1 for raddr_a=9. Port A write x9 -> still busy. Port B write x9=0x42 -> busy 0 and data 0x42. Same-cycle set+B on x9 -> busy remains 1.
- FPU=1, ZFINX=0: write B f3 (addr 35)=0xC0DE -> rdata 0xC0DE, x3 unchanged. FPU=0: addr 35 reads 0 and the write is ignored.
- Fill all registers nonzero and set several busy bits, then pulse clear_req_i -> clear_busy_o high for NUM_TOT-1 cycles (63 with FPU=1), all reads 0 afterwards, busy 0, clear_done_o high exactly 1 cycle. Writes issued during the clear are dropped.
- Assert rst mid-clear at counter=10 -> immediate IDLE, clear_busy_o=0, no clear_done_o pulse, all registers 0.
